// File: rtl/l2_stream_driver.sv
// Producer side of the part2 L2-norm accumulator. Replays a small sample buffer
// onto a/valid_in with a programmable gap, and captures the returned f/valid_out.
module l2_stream_driver #(
    parameter int DEPTH        = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [7:0]               wr_data,
    input  logic [$clog2(DEPTH):0]   len,
    input  logic [1:0]               gap,
    input  logic                     start,
    output logic [7:0]               a,
    output logic                     valid_in,
    input  logic [19:0]              f,
    input  logic                     valid_out,
    input  logic                     overflow,
    output logic                     busy,
    output logic                     done,
    output logic [19:0]              result,
    output logic [7:0]               result_count,
    output logic                     overflow_seen
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [AW:0]   DEPTH_L    = (AW + 1)'(DEPTH);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DRAIN} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW:0]   idx;
    logic [AW:0]   len_q;
    logic [1:0]    gap_q;
    logic [1:0]    gap_cnt;
    logic [DW-1:0] drain_cnt;
    logic [AW:0]   len_clamped;
    logic          start_ok;

    assign start_ok    = (state == IDLE) && start;
    assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;

    // Sample buffer keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_en && !busy)
            mem[wr_addr] <= wr_data;
    end

    // idx always points at the next sample to drive; state describes the current cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            gap_cnt   <= '0;
            drain_cnt <= '0;
            a         <= '0;
            valid_in  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len_clamped;
                        gap_q <= gap;
                        busy  <= 1'b1;
                        if (len_clamped != '0) begin
                            state    <= SEND;
                            a        <= mem[0];
                            valid_in <= 1'b1;
                            idx      <= (AW + 1)'(1);
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_LAST;
                        end
                    end
                end
                SEND: begin
                    if (idx == len_q) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LAST;
                        a         <= '0;
                        valid_in  <= 1'b0;
                    end else if (gap_q != 2'd0) begin
                        state    <= GAP;
                        gap_cnt  <= gap_q - 2'd1;
                        a        <= '0;
                        valid_in <= 1'b0;
                    end else begin
                        a   <= mem[idx[AW-1:0]];
                        idx <= idx + (AW + 1)'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == 2'd0) begin
                        state    <= SEND;
                        a        <= mem[idx[AW-1:0]];
                        valid_in <= 1'b1;
                        idx      <= idx + (AW + 1)'(1);
                    end else begin
                        gap_cnt <= gap_cnt - 2'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A start clears the capture registers, but a same-cycle valid_out/overflow still lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result        <= '0;
            result_count  <= '0;
            overflow_seen <= 1'b0;
        end else begin
            if (valid_out) begin
                result <= f;
                if (start_ok)
                    result_count <= 8'd1;
                else if (result_count != 8'hFF)
                    result_count <= result_count + 8'd1;
            end else if (start_ok) begin
                result       <= '0;
                result_count <= '0;
            end
            overflow_seen <= overflow | (overflow_seen & ~start_ok);
        end
    end

endmodule

// File: tb/tb_l2_stream_driver.sv
// Self-checking bench for l2_stream_driver: scoreboarded sample streams, capture
// behaviour, and a loopback through a behavioural squared-sum accumulator.
module tb_l2_stream_driver;
    localparam int DEPTH = 16;
    localparam int DRAIN = 4;

    typedef struct {
        int         t;
        logic [7:0] v;
    } samp_t;

    typedef struct {
        logic [19:0] fv;
        logic        ov;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [4:0]  len = '0;
    logic [1:0]  gap = '0;
    logic        start = 1'b0;
    logic [7:0]  a;
    logic        valid_in;
    logic [19:0] f;
    logic        valid_out;
    logic        overflow;
    logic        busy;
    logic        done;
    logic [19:0] result;
    logic [7:0]  result_count;
    logic        overflow_seen;

    logic        loop_en = 1'b0;
    logic [19:0] f_drv = '0;
    logic        vo_drv = 1'b0;
    logic        ov_drv = 1'b0;

    logic [19:0] acc_sum;
    logic [19:0] acc_f;
    logic        acc_vo;
    logic        acc_ov;
    logic [20:0] acc_next;

    logic [7:0]  bm [DEPTH];
    samp_t       sb [$];
    res_t        lq [$];
    int          n_cmp = 0;
    int          n_mis = 0;

    always #5 clk = ~clk;

    assign f         = loop_en ? acc_f  : f_drv;
    assign valid_out = loop_en ? acc_vo : vo_drv;
    assign overflow  = loop_en ? acc_ov : ov_drv;

    // Behavioural part2: running 20-bit sum of a*a, carry-out flagged as overflow.
    assign acc_next = {1'b0, acc_sum} + 21'(a) * 21'(a);
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_sum <= '0;
            acc_f   <= '0;
            acc_vo  <= 1'b0;
            acc_ov  <= 1'b0;
        end else begin
            acc_vo <= valid_in;
            acc_ov <= 1'b0;
            if (valid_in) begin
                acc_sum <= acc_next[19:0];
                acc_f   <= acc_next[19:0];
                acc_ov  <= acc_next[20];
            end
        end
    end

    l2_stream_driver #(.DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .gap(gap), .start(start), .a(a), .valid_in(valid_in), .f(f),
        .valid_out(valid_out), .overflow(overflow), .busy(busy), .done(done),
        .result(result), .result_count(result_count), .overflow_seen(overflow_seen)
    );

    task automatic write_buf(input int addr, input logic [7:0] val);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr[3:0];
        wr_data = val;
        bm[addr] = val;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_mis++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, expected 0", busy, k);
        end
    endtask

    // Starts a run and scoreboards every cycle until a few cycles past the expected done.
    // At cycle poke_t (if >0) a second start and a buffer write are attempted while busy.
    task automatic run_stream(input int len_in, input int gap_in, input int poke_t);
        int    l;
        int    exp_done;
        samp_t e;
        l = (len_in > DEPTH) ? DEPTH : len_in;
        for (int k = 0; k < l; k++) begin
            e.t = 1 + k * (gap_in + 1);
            e.v = bm[k];
            sb.push_back(e);
        end
        exp_done = (l == 0) ? 1 + DRAIN : 2 + (l - 1) * (gap_in + 1) + DRAIN;
        @(negedge clk);
        len   = len_in[4:0];
        gap   = gap_in[1:0];
        start = 1'b1;
        for (int t = 1; t <= exp_done + 3; t++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            if (t == poke_t) begin
                start   = 1'b1;
                len     = 5'd2;
                wr_en   = 1'b1;
                wr_addr = 4'd0;
                wr_data = 8'hEE;
            end
            n_cmp++;
            if (valid_in === 1'b1) begin
                if (sb.size() == 0) begin
                    n_mis++;
                    $display("FAIL extra_sample t=%0d: got a=%0h, expected no sample", t, a);
                end else begin
                    e = sb.pop_front();
                    if (e.t != t || a !== e.v) begin
                        n_mis++;
                        $display("FAIL sample t=%0d: got a=%0h, expected a=%0h at t=%0d", t, a, e.v, e.t);
                    end
                end
            end else if (a !== 8'h00) begin
                n_mis++;
                $display("FAIL a_idle t=%0d: got %0h, expected 0", t, a);
            end
            n_cmp++;
            if (busy !== (t < exp_done)) begin
                n_mis++;
                $display("FAIL busy t=%0d: got %0b, expected %0b", t, busy, t < exp_done);
            end
            n_cmp++;
            if (done !== (t == exp_done)) begin
                n_mis++;
                $display("FAIL done t=%0d: got %0b, expected %0b", t, done, t == exp_done);
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        n_cmp++;
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL missing_samples: got %0d left, expected 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset_state();
        #1;
        n_cmp++;
        if ({a, valid_in, busy, done, result, result_count, overflow_seen} !== '0) begin
            n_mis++;
            $display("FAIL reset_state: got a=%0h vi=%0b busy=%0b done=%0b res=%0h cnt=%0d ovs=%0b, expected all 0",
                     a, valid_in, busy, done, result, result_count, overflow_seen);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) write_buf(k, 8'(k + 1));
        run_stream(4, 0, 0);
    endtask

    task automatic test_gap();
        run_stream(4, 2, 0);
        run_stream(3, 3, 0);
    endtask

    task automatic test_len_boundaries();
        run_stream(0, 0, 0);
        for (int k = 0; k < DEPTH; k++) write_buf(k, 8'(k * 7 + 3));
        run_stream(31, 0, 0);
        run_stream(16, 1, 0);
    endtask

    task automatic test_busy_ignore();
        run_stream(5, 1, 2);
        run_stream(1, 0, 0);
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        len   = 5'd8;
        gap   = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        vo_drv = 1'b1;
        f_drv  = 20'h00ABC;
        @(negedge clk);
        vo_drv = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (valid_in !== 1'b1 || result !== 20'h00ABC) begin
            n_mis++;
            $display("FAIL pre_reset: got vi=%0b res=%0h, expected vi=1 res=abc", valid_in, result);
        end
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({a, valid_in, busy, done, result, result_count, overflow_seen} !== '0) begin
            n_mis++;
            $display("FAIL reset_midrun: got a=%0h vi=%0b busy=%0b done=%0b res=%0h cnt=%0d ovs=%0b, expected all 0",
                     a, valid_in, busy, done, result, result_count, overflow_seen);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || valid_in !== 1'b0) begin
                n_mis++;
                $display("FAIL after_reset t=%0d: got done=%0b busy=%0b vi=%0b, expected 0", t, done, busy, valid_in);
            end
        end
        run_stream(8, 1, 0);
    endtask

    task automatic test_capture_sat();
        int exp_cnt;
        run_stream(0, 0, 0);
        exp_cnt = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            n_cmp++;
            if (result_count !== 8'(exp_cnt)) begin
                n_mis++;
                $display("FAIL count i=%0d: got %0d, expected %0d", i, result_count, exp_cnt);
            end
            vo_drv = 1'b1;
            f_drv  = 20'(i);
            exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
        end
        @(negedge clk);
        vo_drv = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (result_count !== 8'd255 || result !== 20'd300) begin
            n_mis++;
            $display("FAIL saturate: got cnt=%0d res=%0d, expected cnt=255 res=300", result_count, result);
        end
    endtask

    task automatic test_overflow_sticky();
        @(negedge clk);
        n_cmp++;
        if (overflow_seen !== 1'b0) begin
            n_mis++;
            $display("FAIL ovs_clear: got %0b, expected 0", overflow_seen);
        end
        ov_drv = 1'b1;
        @(negedge clk);
        ov_drv = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            n_cmp++;
            if (overflow_seen !== 1'b1) begin
                n_mis++;
                $display("FAIL ovs_sticky t=%0d: got %0b, expected 1", t, overflow_seen);
            end
        end
    endtask

    task automatic test_start_coincident();
        @(negedge clk);
        len    = 5'd0;
        start  = 1'b1;
        vo_drv = 1'b1;
        f_drv  = 20'h12345;
        @(negedge clk);
        start  = 1'b0;
        vo_drv = 1'b0;
        n_cmp++;
        if (result_count !== 8'd1 || result !== 20'h12345 || overflow_seen !== 1'b0) begin
            n_mis++;
            $display("FAIL start_vo: got cnt=%0d res=%0h ovs=%0b, expected cnt=1 res=12345 ovs=0",
                     result_count, result, overflow_seen);
        end
        wait_idle();
        start  = 1'b1;
        ov_drv = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        ov_drv = 1'b0;
        n_cmp++;
        if (result_count !== 8'd0 || result !== 20'd0 || overflow_seen !== 1'b1) begin
            n_mis++;
            $display("FAIL start_ov: got cnt=%0d res=%0h ovs=%0b, expected cnt=0 res=0 ovs=1",
                     result_count, result, overflow_seen);
        end
        wait_idle();
    endtask

    task automatic test_loopback();
        longint      s;
        res_t        r;
        logic [19:0] exp_res;
        int          exp_cnt;
        logic        exp_ovs;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < DEPTH; k++) write_buf(k, 8'hFF);
        loop_en = 1'b1;
        s = 0;
        for (int run = 0; run < 2; run++) begin
            for (int k = 0; k < DEPTH; k++) begin
                s = s + 65025;
                r.ov = (s >= 1048576);
                if (r.ov) s = s - 1048576;
                r.fv = 20'(s);
                lq.push_back(r);
            end
            exp_res = '0;
            exp_cnt = 0;
            exp_ovs = 1'b0;
            @(negedge clk);
            len   = 5'd16;
            gap   = 2'd0;
            start = 1'b1;
            for (int t = 1; t <= 28; t++) begin
                @(negedge clk);
                start = 1'b0;
                n_cmp++;
                if (result !== exp_res || result_count !== 8'(exp_cnt) || overflow_seen !== exp_ovs) begin
                    n_mis++;
                    $display("FAIL loopback run=%0d t=%0d: got res=%0h cnt=%0d ovs=%0b, expected res=%0h cnt=%0d ovs=%0b",
                             run, t, result, result_count, overflow_seen, exp_res, exp_cnt, exp_ovs);
                end
                if (valid_out === 1'b1) begin
                    n_cmp++;
                    if (lq.size() == 0) begin
                        n_mis++;
                        $display("FAIL loop_extra t=%0d: got f=%0h, expected no result", t, f);
                    end else begin
                        r = lq.pop_front();
                        if (f !== r.fv || overflow !== r.ov) begin
                            n_mis++;
                            $display("FAIL loop_f t=%0d: got f=%0h ov=%0b, expected f=%0h ov=%0b", t, f, overflow, r.fv, r.ov);
                        end
                        exp_res = r.fv;
                        exp_cnt++;
                        exp_ovs = exp_ovs | r.ov;
                    end
                end
            end
            n_cmp++;
            if (lq.size() != 0 || exp_ovs !== (run == 1)) begin
                n_mis++;
                $display("FAIL loop_end run=%0d: got %0d pending ovs=%0b, expected 0 pending ovs=%0b",
                         run, lq.size(), exp_ovs, run == 1);
            end
            lq.delete();
        end
        loop_en = 1'b0;
    endtask

    initial begin
        test_reset_state();
        test_back_to_back();
        test_gap();
        test_len_boundaries();
        test_busy_ignore();
        test_reset_midrun();
        test_capture_sat();
        test_overflow_sticky();
        test_start_coincident();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/l2_stream_driver.md
# l2_stream_driver

Transmit-side companion to the `part2` L2-norm accumulator. It holds a small sample buffer loaded over a simple write port. On `start`, it drives the samples onto the accumulator's `a`/`valid_in` input with a programmable idle gap between samples. It also captures every `f` the accumulator returns on `valid_out`, together with a sticky overflow flag. It sits between the control/test logic and the `part2` datapath, and is the producer end of the `a`/`valid_in` → `f`/`valid_out` protocol.

## Interface
- `DEPTH`, 16: number of 8-bit sample slots; a power of two, ≥2.
- `DRAIN_CYCLES`, 4: idle cycles held after the last sample before `done`; ≥1.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high. Clears all state except the sample buffer.
- `wr_en` in 1: write one sample into the buffer.
- `wr_addr` in log2(DEPTH): buffer slot to write.
- `wr_data` in 8: sample value to write.
- `len` in log2(DEPTH)+1: number of samples to send, sampled at `start`. Values above DEPTH are clamped to DEPTH.
- `gap` in 2: idle cycles inserted between consecutive samples (0–3), sampled at `start`.
- `start` in 1: begin a run. Accepted only in IDLE.
- `a` out 8: sample to the accumulator; 0 when `valid_in`=0.
- `valid_in` out 1: sample valid to the accumulator.
- `f` in 20: accumulator result.
- `valid_out` in 1: `f` is valid this cycle.
- `overflow` in 1: accumulator overflow indication.
- `busy` out 1: a run is in progress.
- `done` out 1: one-cycle pulse at the end of a run.
- `result` out 20: last `f` captured.
- `result_count` out 8: number of `valid_out` cycles seen since the last accepted start; saturates at 255.
- `overflow_seen` out 1: sticky; set if `overflow`=1 in any cycle since the last accepted start.

## Operation
- Buffer: DEPTH×8 registers.
  - A write happens on a clock edge with `wr_en`=1, only when not busy. Writes while busy are dropped.
  - The buffer is not cleared by reset.
- FSM states are IDLE, SEND, GAP and DRAIN. The reset state is IDLE.
  - **IDLE:** `start`=1 latches `len` (clamped) as L and `gap` as G, and clears `result`, `result_count` and `overflow_seen`. Go to SEND if L>0, else go to DRAIN.
  - **SEND:** drive `a`=buf[idx], `valid_in`=1 for one cycle, then idx+1. If this was the last sample, go to DRAIN. Otherwise go to GAP if G>0, or stay in SEND if G=0.
  - **GAP:** `valid_in`=0, `a`=0 for exactly G cycles, then return to SEND.
  - **DRAIN:** `valid_in`=0 for DRAIN_CYCLES cycles. Then return to IDLE and pulse `done`.
- `start` is ignored outside IDLE. A `start` in the same cycle as the `done` pulse is accepted.
- Capture runs in every state, including IDLE:
  - On `valid_out`=1: `result`←`f` and `result_count`←sat(`result_count`+1).
  - On `overflow`=1: `overflow_seen`←1.
- If an accepted `start` coincides with `valid_out`=1, the clear is applied first: `result`=`f` and `result_count`=1. The same rule applies to `overflow`.
- `a`, `valid_in`, `busy` and `done` are registered outputs, with no combinational path from any input.

## Timing
- Reset value of every output is 0, asynchronously. A reset mid-run aborts the run immediately: `valid_in` drops to 0, no `done` is pulsed, and the FSM returns to IDLE.
- `start` sampled high at edge N gives the first sample with `valid_in`=1 in cycle N+1. `busy`=1 from cycle N+1.
- Sample k (0-based) is driven in cycle N+1+k·(G+1).
- DRAIN occupies the DRAIN_CYCLES cycles after the last sample.
- `done`=1 for one cycle at N+2+(L−1)(G+1)+DRAIN_CYCLES, with `busy`=0 in that same cycle.
- For L=0: DRAIN runs in cycles N+1..N+DRAIN_CYCLES, and `done` is at N+1+DRAIN_CYCLES.
- `result`, `result_count` and `overflow_seen` update on the edge after the input is seen (1-cycle latency).

## Test plan
- **Reset:** assert `reset` mid-clock during SEND → all outputs 0 immediately; no `done`; a following `start` runs normally from sample 0.
- **Back-to-back run:** write buf[0..3]=1,2,3,4; `len`=4, `gap`=0, `start` at N.
  - `valid_in` is high in N+1..N+4 with `a`=1,2,3,4.
  - `done` pulses at N+9 (DRAIN_CYCLES=4).
  - `result` = last `f` returned.
- **Gap run:** same buffer, `gap`=2 → samples in cycles N+1, N+4, N+7 and N+10, with `valid_in`=0 and `a`=0 between them; `done` at N+15.
- **Boundaries:**
  - `len`=0 → no `valid_in`; `done` at N+5.
  - `len`=31 → exactly 16 samples sent.
  - `start` while busy → ignored.
  - `wr_en` while busy → buffer unchanged.
- **Capture:**
  - 300 `valid_out` pulses → `result_count`=255.
  - One `overflow` pulse → `overflow_seen` stays 1 until the next accepted `start`.
  - `start` coincident with `valid_out` → `result_count`=1.
- **Loopback with `part2`:** send a=255 repeatedly → `f` sequence matches the accumulator's arithmetic; `overflow_seen` sets exactly when `part2` flags overflow.
